// File: rtl/output_unit_fsm.sv
// Router output-port controller: round-robin grants the port to one input, forwards its flits, releases on tail.
// Latency: grant ack is combinational in the IDLE cycle; o_flit/o_flit_valid are registered one cycle after the pop.
// Backpressure: sends are gated on downstream credits; with none left the port parks in WAITING until i_credit.
// Optional build macro OU_CREDIT_CHECK_EN adds sticky o_credit_err for credit returns beyond full capacity.

package router_pkg;

    localparam int FLIT_SIZE = 16;

    // Flit layout: [FLIT_W-1] valid, [FLIT_W-2 -: 2] type, remainder payload.
    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } FLIT_TYPE_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        WAITING = 2'b10
    } GLOBAL_STATE_t;

endpackage

module output_unit_fsm
    import router_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = FLIT_SIZE,
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1),
    parameter int OWN_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        i_switch_req,
    input  logic [NUM_IN*FLIT_W-1:0] i_flit,
    output logic [NUM_IN-1:0]        o_switch_ack,
    output logic [NUM_IN-1:0]        o_flit_pop,
    output logic [FLIT_W-1:0]        o_flit,
    output logic                     o_flit_valid,
    input  logic                     i_credit,
    output GLOBAL_STATE_t            o_state,
    output logic [OWN_W-1:0]         o_owner,
    output logic                     o_packet_done
`ifdef OU_CREDIT_CHECK_EN
    ,
    output logic                     o_credit_err
`endif
);

    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);
    localparam logic [OWN_W-1:0] LAST_IN     = OWN_W'(NUM_IN - 1);

    GLOBAL_STATE_t      state_q;
    logic [OWN_W-1:0]   owner_q;
    logic [OWN_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   credit_q;
    logic [CNT_W-1:0]   credit_d;
    logic [FLIT_W-1:0]  flit_q;
    logic               flit_vld_q;
    logic               done_q;
`ifdef OU_CREDIT_CHECK_EN
    logic               err_q;
`endif

    logic [FLIT_W-1:0]  owner_flit;
    logic               owner_vld;
    logic               owner_tail;
    logic               credit_ok;
    logic               send;
    logic               gnt_found;
    logic [OWN_W-1:0]   gnt_idx;
    logic               grant_now;
    logic [OWN_W-1:0]   ptr_next;

    // Select the current owner's head-of-queue flit
    always_comb begin
        owner_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q == OWN_W'(i)) begin
                owner_flit = i_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign owner_vld  = owner_flit[FLIT_W-1];
    assign owner_tail = (FLIT_TYPE_t'(owner_flit[FLIT_W-2 -: 2]) == TAIL_FLIT);
    assign credit_ok  = (credit_q != '0);
    // Reset gates pops so a flit is never consumed in a cycle that abandons the packet.
    assign send       = !reset && (state_q == ACTIVE) && owner_vld && credit_ok;
    assign ptr_next   = (owner_q == LAST_IN) ? '0 : owner_q + 1'b1;

    // Round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        int               cand;
        logic [OWN_W-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            cand_idx = OWN_W'(cand);
            if (!gnt_found && i_switch_req[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign grant_now = !reset && (state_q == IDLE) && gnt_found;

    // One-hot ack to the winner and one-hot pop to the owner
    always_comb begin
        o_switch_ack = '0;
        o_flit_pop   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            o_switch_ack[i] = grant_now && (gnt_idx == OWN_W'(i));
            o_flit_pop[i]   = send && (owner_q == OWN_W'(i));
        end
    end

    // Credit accounting: a return and a send in the same cycle cancel; returns at full are dropped
    always_comb begin
        credit_d = credit_q;
        if (send && !i_credit) begin
            credit_d = credit_q - 1'b1;
        end else if (!send && i_credit && (credit_q != CREDITS_MAX)) begin
            credit_d = credit_q + 1'b1;
        end
    end

    // Port FSM with registered outputs, credit counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            credit_q   <= CREDITS_MAX;
            flit_q     <= '0;
            flit_vld_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef OU_CREDIT_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            credit_q   <= credit_d;
            flit_vld_q <= send;
            done_q     <= send && owner_tail;
            if (send) begin
                flit_q <= owner_flit;
            end
`ifdef OU_CREDIT_CHECK_EN
            if (i_credit && (credit_q == CREDITS_MAX) && !send) begin
                err_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        owner_q <= gnt_idx;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (send) begin
                        if (owner_tail) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_next;
                        end
                    end else if (owner_vld && !i_credit) begin
                        // Out of credit with a flit ready; a same-cycle return keeps us ACTIVE.
                        state_q <= WAITING;
                    end
                end
                WAITING: begin
                    if (i_credit) begin
                        state_q <= ACTIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_state       = state_q;
    assign o_owner       = owner_q;
    assign o_flit        = flit_q;
    assign o_flit_valid  = flit_vld_q;
    assign o_packet_done = done_q;
`ifdef OU_CREDIT_CHECK_EN
    assign o_credit_err  = err_q;
`endif

endmodule

// File: tb/tb_output_unit_fsm.sv
// Bench for output_unit_fsm: directed packet scenarios with a flit scoreboard.
// Expected flits are queued in the order the bench expects the port to serve them.
// Outputs are sampled at negedge (combinational ack/pop) and #1 after posedge (registered).

module tb_output_unit_fsm;
    import router_pkg::*;

    localparam int NI = 5;
    localparam int FW = FLIT_SIZE;
    localparam int CR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI-1:0]     req;
    logic [NI*FW-1:0]  flits;
    logic [NI-1:0]     ack;
    logic [NI-1:0]     pop;
    logic [FW-1:0]     oflit;
    logic              oflit_vld;
    logic              credit;
    GLOBAL_STATE_t     st;
    logic [2:0]        owner;
    logic              done;
`ifdef OU_CREDIT_CHECK_EN
    logic              credit_err;
`endif

    always #5 clk = ~clk;

    output_unit_fsm #(.NUM_IN(NI), .FLIT_W(FW), .CREDITS(CR)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_switch_req  (req),
        .i_flit        (flits),
        .o_switch_ack  (ack),
        .o_flit_pop    (pop),
        .o_flit        (oflit),
        .o_flit_valid  (oflit_vld),
        .i_credit      (credit),
        .o_state       (st),
        .o_owner       (owner),
        .o_packet_done (done)
`ifdef OU_CREDIT_CHECK_EN
        ,
        .o_credit_err  (credit_err)
`endif
    );

    logic [FW-1:0] inq [NI][$];
    int            pend [NI];
    logic [FW-1:0] exp_q [$];
    int            grant_q [$];
    int            tests_run = 0;
    int            fails = 0;
    int            flits_seen = 0;
    logic [NI-1:0] last_ack, last_pop;
    bit            auto_credit = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [FW-1:0] mk(FLIT_TYPE_t t, logic [12:0] p);
        return {1'b1, t, p};
    endfunction

    function automatic logic is_tail(logic [FW-1:0] f);
        return FLIT_TYPE_t'(f[FW-2 -: 2]) == TAIL_FLIT;
    endfunction

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            flits[i*FW +: FW] = (inq[i].size() != 0) ? inq[i][0] : '0;
            req[i]            = (pend[i] > 0);
        end
    endtask

    task automatic push_flit(int port, logic [FW-1:0] f);
        inq[port].push_back(f);
        exp_q.push_back(f);
    endtask

    // Packet of n flits: HEAD, BODY..., TAIL; index 'stray' is an extra HEAD mid-packet
    task automatic load_pkt(int port, int n, logic [12:0] base, int stray);
        for (int j = 0; j < n; j++) begin
            FLIT_TYPE_t t;
            t = (j == 0 || j == stray) ? HEAD_FLIT : ((j == n - 1) ? TAIL_FLIT : BODY_FLIT);
            push_flit(port, mk(t, base + 13'(j)));
        end
        pend[port]++;
        drive();
    endtask

    task automatic flush_model();
        for (int i = 0; i < NI; i++) begin
            inq[i].delete();
            pend[i] = 0;
        end
        exp_q.delete();
        grant_q.delete();
        flits_seen  = 0;
        credit      = 1'b0;
        auto_credit = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: sample combinational outputs, advance, update upstream model, score output flit
    task automatic cycle();
        logic [NI-1:0] a, p;
        logic [FW-1:0] e;
        @(negedge clk);
        a = ack;
        p = pop;
        last_ack = a;
        last_pop = p;
        chk("ack_onehot", 32'($onehot0(a)), 1);
        chk("pop_onehot", 32'($onehot0(p)), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (a[i]) begin
                grant_q.push_back(i);
                if (pend[i] > 0) pend[i]--;
            end
            if (p[i]) begin
                tests_run++;
                assert (inq[i].size() != 0) else begin
                    fails++;
                    $error("FAIL pop_empty: observed pop on input %0d expected no pop", i);
                end
                if (inq[i].size() != 0) void'(inq[i].pop_front());
            end
        end
        credit = auto_credit && (p != '0);
        drive();
        if (oflit_vld) begin
            tests_run++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_extra: observed flit %0h expected none", oflit);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_flit", 32'(oflit), 32'(e));
                chk("sb_done", 32'(done), 32'(is_tail(e)));
                flits_seen++;
            end
        end else begin
            chk("done_no_flit", 32'(done), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        credit = 1'b0;
        req    = '0;
        flits  = '0;

        // Reset state
        do_reset();
        chk("rst_state", st, IDLE);
        chk("rst_vld", 32'(oflit_vld), 0);
        chk("rst_flit", 32'(oflit), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_credit", 32'(dut.credit_q), CR);
        chk("rst_ptr", 32'(dut.ptr_q), 0);
`ifdef OU_CREDIT_CHECK_EN
        chk("rst_err", 32'(credit_err), 0);
`endif
        cycle();
        chk("idle_ack", 32'(last_ack), 0);
        chk("idle_pop", 32'(last_pop), 0);

        // Single packet on input 2
        load_pkt(2, 3, 13'h100, -1);
        cycle();
        chk("p1_ack", 32'(last_ack), 32'b00100);
        chk("p1_owner", 32'(owner), 2);
        chk("p1_state_act", st, ACTIVE);
        repeat (3) cycle();
        chk("p1_flits", flits_seen, 3);
        chk("p1_state_idle", st, IDLE);
        chk("p1_credit", 32'(dut.credit_q), 1);
        cycle();
        chk("p1_vld_after", 32'(oflit_vld), 0);
        chk("p1_grants", grant_q.size(), 1);
        chk("p1_sb_empty", exp_q.size(), 0);

        // Round-robin between inputs 0 and 3, with 0 re-requesting
        do_reset();
        auto_credit = 1'b1;
        load_pkt(0, 2, 13'h200, -1);
        load_pkt(3, 2, 13'h300, -1);
        load_pkt(0, 2, 13'h210, -1);
        repeat (15) cycle();
        chk("rr_grants", grant_q.size(), 3);
        chk("rr_g0", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
        chk("rr_g1", (grant_q.size() > 1) ? grant_q[1] : -1, 3);
        chk("rr_g2", (grant_q.size() > 2) ? grant_q[2] : -1, 0);
        chk("rr_flits", flits_seen, 6);
        chk("rr_sb_empty", exp_q.size(), 0);
        chk("rr_credit", 32'(dut.credit_q), CR);

        // Credit stall: 6-flit packet (stray HEAD inside), no returns
        do_reset();
        load_pkt(1, 6, 13'h400, 2);
        repeat (7) cycle();
        chk("st_flits4", flits_seen, 4);
        chk("st_waiting", st, WAITING);
        chk("st_pop0", 32'(last_pop), 0);
        chk("st_credit0", 32'(dut.credit_q), 0);
        credit = 1'b1;
        cycle();
        chk("st_pop_credit_cyc", 32'(last_pop), 0);
        chk("st_active", st, ACTIVE);
        repeat (3) cycle();
        chk("st_flits5", flits_seen, 5);
        chk("st_waiting2", st, WAITING);
        credit = 1'b1;
        repeat (3) cycle();
        chk("st_flits6", flits_seen, 6);
        chk("st_idle", st, IDLE);
        chk("st_sb_empty", exp_q.size(), 0);

        // Credit return coincident with a send
        do_reset();
        load_pkt(4, 4, 13'h500, -1);
        repeat (2) cycle();
        chk("sim_credit3", 32'(dut.credit_q), 3);
        credit = 1'b1;
        cycle();
        chk("sim_pop", 32'(last_pop), 32'b10000);
        chk("sim_credit_same", 32'(dut.credit_q), 3);
        repeat (3) cycle();
        chk("sim_credit_end", 32'(dut.credit_q), 1);
        chk("sim_idle", st, IDLE);
        chk("sim_sb_empty", exp_q.size(), 0);

        // Reset after the 2nd of 5 flits
        do_reset();
        load_pkt(0, 5, 13'h600, -1);
        repeat (3) cycle();
        chk("mr_flits2", flits_seen, 2);
        reset = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        chk("mr_state", st, IDLE);
        chk("mr_credit", 32'(dut.credit_q), CR);
        chk("mr_vld", 32'(oflit_vld), 0);
        chk("mr_flit", 32'(oflit), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_owner", 32'(owner), 0);
        reset = 1'b0;
        // New packet with a bubble between HEAD and TAIL
        push_flit(2, mk(HEAD_FLIT, 13'h700));
        pend[2]++;
        drive();
        cycle();
        chk("mr_ack", 32'(last_ack), 32'b00100);
        repeat (3) cycle();
        chk("bub_state", st, ACTIVE);
        chk("bub_vld", 32'(oflit_vld), 0);
        chk("bub_pop", 32'(last_pop), 0);
        push_flit(2, mk(TAIL_FLIT, 13'h701));
        drive();
        repeat (2) cycle();
        chk("bub_flits", flits_seen, 2);
        chk("bub_idle", st, IDLE);
        chk("bub_sb_empty", exp_q.size(), 0);

        // Credit return at full capacity while idle
        do_reset();
        credit = 1'b1;
        cycle();
        chk("ov_credit", 32'(dut.credit_q), CR);
`ifdef OU_CREDIT_CHECK_EN
        chk("ov_err", 32'(credit_err), 1);
        repeat (3) cycle();
        chk("ov_err_sticky", 32'(credit_err), 1);
`endif
        repeat (2) cycle();
        chk("ov_credit_hold", 32'(dut.credit_q), CR);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/output_unit_fsm.md
Name: output_unit_fsm

Overview:
- Per-output-port controller of the router; the responder to input units' switch requests.
- Arbitrates round-robin among requesting input units, grants the port to one packet, and forwards that owner's flits downstream under credit-based flow control.
- Releases the port on the tail flit.
- One instance per router output port, between crossbar inputs and the output link.

Parameters:
NUM_IN, 5, number of input units that can request this port
FLIT_W, FLIT_SIZE, flit width in bits; bit FLIT_W-1 is the valid bit, type field per router_pkg FLIT_TYPE_t
CREDITS, 4, downstream buffer depth in flits; initial and maximum credit count
CNT_W, $clog2(CREDITS+1), credit counter width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_switch_req  input  NUM_IN  per-input request for this port (level, held until acked)
i_flit  input  NUM_IN*FLIT_W  head-of-queue flit from each input unit
o_switch_ack  output  NUM_IN  one-hot grant pulse to the winning input
o_flit_pop  output  NUM_IN  one-hot, owner's flit consumed this cycle
o_flit  output  FLIT_W  registered outgoing flit
o_flit_valid  output  1  o_flit valid this cycle
i_credit  input  1  one-cycle pulse, downstream freed one buffer slot
o_state  output  GLOBAL_STATE_t  current port state (IDLE/ACTIVE/WAITING)
o_owner  output  $clog2(NUM_IN)  index of current owner, valid when not IDLE
o_packet_done  output  1  one-cycle pulse when tail flit is forwarded

Behaviour:
- Reset:
  - state=IDLE, o_switch_ack=0, o_flit_pop=0, o_flit=0, o_flit_valid=0, o_owner=0, o_packet_done=0.
  - Credit count=CREDITS, round-robin pointer=0.
  - Reset mid-packet abandons the packet with no tail emitted.
- IDLE:
  - If any i_switch_req is set, pick the first requester at or after the pointer (wrapping modulo NUM_IN).
  - Assert o_switch_ack for that input for exactly one cycle (combinational in the IDLE cycle), latch o_owner, go to ACTIVE next cycle.
  - No request: stay IDLE.
- ACTIVE:
  - Send condition: owner flit valid bit set AND credit count>0.
  - On send: o_flit_pop[owner]=1 in that cycle; o_flit<=owner flit and o_flit_valid<=1 on the next edge (latency 1); credit decrements.
  - Owner flit valid with credit count=0 -> WAITING.
  - Owner flit invalid -> stay ACTIVE, o_flit_valid=0.
- WAITING: no send; on i_credit return to ACTIVE. The flit is sent in the ACTIVE cycle, not in the cycle the credit arrives.
- Tail:
  - When the sent flit's type is TAIL_FLIT: o_packet_done pulses together with o_flit_valid.
  - State -> IDLE; pointer <= owner+1 modulo NUM_IN.
  - The first arbitration for the next packet happens in the cycle after the tail is sent.
- Non-tail flits (including a stray HEAD while ACTIVE) are forwarded unchanged.
- Requests from non-owners while ACTIVE/WAITING: ignored, no ack. Requesters keep waiting.
- Credits:
  - i_credit and a send in the same cycle leave the count unchanged.
  - i_credit when count==CREDITS is dropped; count saturates.
  - Count never underflows, since sends are gated on count>0.
- o_state reflects the registered current state.

Optional Feature:
- Macro OU_CREDIT_CHECK_EN:
  - When defined: adds output o_credit_err (1 bit), sticky. Set on i_credit while count==CREDITS without a simultaneous send. Cleared only by reset.
  - When undefined: port absent, overflow silently dropped, behaviour otherwise identical.

Test Plan:
- Single packet: reset, req on input 2 with HEAD,BODY,TAIL available back-to-back, no credit return.
  - ack[2] one cycle, o_owner=2.
  - Three o_flit_valid cycles, o_packet_done with the TAIL.
  - Credit count 4->1, state back to IDLE.
- Round-robin: inputs 0 and 3 request together from reset.
  - Input 0 is granted first.
  - After its tail, input 3 is granted while 0 re-requests; then 0.
- Credit stall: CREDITS=4, 6-flit packet, no i_credit.
  - 4 flits sent, state=WAITING, o_flit_pop=0.
  - A single i_credit pulse -> exactly one more flit.
- Simultaneous credit and send: i_credit in the same cycle as a send. Count unchanged (e.g. stays 3).
- Reset mid-packet: assert reset after the 2nd of 5 flits.
  - Next cycle: IDLE, credits=4, outputs 0.
  - New req granted normally.
- Overflow with OU_CREDIT_CHECK_EN: i_credit while idle at full credits -> o_credit_err=1 and stays 1; without the macro, count stays 4.
